// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key event sequencer: folds E0/F0 prefixes into single {ext, brk, code}
// events, queues them in a small first-word-fall-through FIFO and throttles
// the receiver through rx_en while the queue is full.
module ps2_key_event_ctrl #(
  parameter int FIFO_AW        = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] dout,
  output logic       rx_en,
  input  logic       rd_tick,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       empty,
  output logic       full,
  output logic       seq_error
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]      TERM      = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic                 seq_error_reg;
  logic [9:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]     count_reg;

  logic                 push_req;
  logic [9:0]           push_data;
  logic                 byte_err;
  logic                 timeout;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;
  logic                 is_empty;
  logic                 is_full;
  logic [9:0]           head;

  // Classify the incoming byte against the current prefix state; a stalled
  // prefix (no byte before terminal count) is abandoned.
  always_comb begin
    state_next = state_reg;
    push_req   = 1'b0;
    push_data  = {2'b00, dout};
    byte_err   = 1'b0;
    timeout    = 1'b0;
    if (rx_done_tick) begin
      if (dout == 8'h00 || dout == 8'hFF) begin
        // receiver overrun marker: whatever sequence was in flight is lost
        byte_err   = 1'b1;
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (dout == 8'hE0) begin
              state_next = EXT;
            end else if (dout == 8'hF0) begin
              state_next = BRK;
            end else if (!(dout inside {8'hAA, 8'hFA, 8'hEE, 8'hFE})) begin
              push_req  = 1'b1;
              push_data = {2'b00, dout};
            end
          end
          EXT: begin
            if (dout == 8'hF0) begin
              state_next = EXT_BRK;
            end else if (dout == 8'hE0) begin
              byte_err = 1'b1;
            end else begin
              push_req   = 1'b1;
              push_data  = {2'b10, dout};
              state_next = IDLE;
            end
          end
          BRK: begin
            state_next = IDLE;
            if (dout == 8'hE0 || dout == 8'hF0) begin
              byte_err = 1'b1;
            end else begin
              push_req  = 1'b1;
              push_data = {2'b01, dout};
            end
          end
          EXT_BRK: begin
            state_next = IDLE;
            if (dout == 8'hE0 || dout == 8'hF0) begin
              byte_err = 1'b1;
            end else begin
              push_req  = 1'b1;
              push_data = {2'b11, dout};
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end else if (state_reg != IDLE && cnt_reg == TERM) begin
      timeout    = 1'b1;
      state_next = IDLE;
    end
  end

  assign is_empty = (count_reg == '0);
  assign is_full  = (count_reg == DEPTH_CNT);
  assign pop      = rd_tick & ~is_empty;
  // a pop in the same cycle frees the slot the push needs
  assign push_ok  = push_req & (~is_full | pop);
  assign drop     = push_req & is_full & ~pop;

  // Prefix FSM, inter-byte timeout counter and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      seq_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      seq_error_reg <= byte_err | timeout | drop;
      if (state_reg == IDLE || rx_done_tick || timeout) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Event storage; contents need no reset because empty gates the head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  assign head      = mem[rd_ptr_reg];
  assign key_code  = is_empty ? 8'h00 : head[7:0];
  assign key_brk   = is_empty ? 1'b0  : head[8];
  assign key_ext   = is_empty ? 1'b0  : head[9];
  assign empty     = is_empty;
  assign full      = is_full;
  assign rx_en     = ~is_full;
  assign seq_error = seq_error_reg;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: stimulus pushes expected events into a
// scoreboard queue, a monitor pops and compares on every accepted rd_tick.
module tb_ps2_key_event_ctrl;

  localparam int AW = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] dout = 8'h00;
  logic       rx_en;
  logic       rd_tick = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       empty;
  logic       full;
  logic       seq_error;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int err_exp  = 0;
  logic [9:0] exp_q[$];

  ps2_key_event_ctrl #(.FIFO_AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .dout(dout),
    .rx_en(rx_en), .rd_tick(rd_tick), .key_code(key_code), .key_ext(key_ext),
    .key_brk(key_brk), .empty(empty), .full(full), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One clock of stimulus; called #1 after a posedge, returns #1 after the next.
  task automatic cyc(input logic rx, input logic [7:0] b, input logic rd);
    rx_done_tick = rx;
    dout         = b;
    rd_tick      = rd;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    rd_tick      = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic pop1();
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  // Monitor: compare the head whenever the consumer pops a non-empty FIFO.
  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!reset && seq_error) err_seen++;
      if (!reset && rd_tick && !empty) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got %0h expected none", {key_ext, key_brk, key_code});
        end else begin
          e = exp_q.pop_front();
          chk("event", {22'd0, key_ext, key_brk, key_code}, {22'd0, e});
        end
      end
    end
  end

  initial begin : stim
    @(posedge clk);
    #1;
    do_reset();
    // reset state
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rx_en", rx_en, 1);
    chk("rst_seq_error", seq_error, 0);
    chk("rst_head", {key_ext, key_brk, key_code}, 0);

    // 1: plain make code
    send(8'h1C); exp_q.push_back({2'b00, 8'h1C});
    chk("t1_empty", empty, 0);
    chk("t1_head", {key_ext, key_brk, key_code}, {2'b00, 8'h1C});
    pop1();
    chk("t1_empty_after_pop", empty, 1);

    // 2: break code, F0 alone produces nothing
    send(8'hF0);
    chk("t2_no_event_f0", empty, 1);
    send(8'h1C); exp_q.push_back({2'b01, 8'h1C});
    pop1();
    chk("t2_single_event", empty, 1);

    // 3: extended make then extended break
    send(8'hE0); send(8'h75); exp_q.push_back({2'b10, 8'h75});
    send(8'hE0); send(8'hF0); send(8'h75); exp_q.push_back({2'b11, 8'h75});
    pop1(); pop1();

    // discards, malformed sequences and overrun
    send(8'hAA); send(8'hFA);
    chk("discard_empty", empty, 1);
    send(8'hF0); send(8'hE0); err_exp++;
    chk("brk_e0_err", seq_error, 1);
    send(8'hE0); send(8'hE0); err_exp++;
    chk("ext_e0_err", seq_error, 1);
    send(8'h75); exp_q.push_back({2'b10, 8'h75});
    chk("ext_e0_err_pulse", seq_error, 0);
    send(8'hE0); send(8'h00); err_exp++;
    chk("overrun_err", seq_error, 1);
    send(8'h1C); exp_q.push_back({2'b00, 8'h1C});
    pop1(); pop1();
    chk("overrun_empty", empty, 1);

    // 4: fill, drop on full, push+pop at full, drain
    send(8'h15); exp_q.push_back({2'b00, 8'h15});
    send(8'h16); exp_q.push_back({2'b00, 8'h16});
    send(8'h1E); exp_q.push_back({2'b00, 8'h1E});
    chk("t4_not_full_3", full, 0);
    send(8'h26); exp_q.push_back({2'b00, 8'h26});
    chk("t4_full", full, 1);
    chk("t4_rx_en", rx_en, 0);
    send(8'h25); err_exp++;
    chk("t4_drop_err", seq_error, 1);
    chk("t4_still_full", full, 1);
    cyc(1'b1, 8'h2D, 1'b1); exp_q.push_back({2'b00, 8'h2D});
    chk("t4_pushpop_full", full, 1);
    chk("t4_pushpop_no_err", seq_error, 0);
    pop1();
    chk("t4_rx_en_back", rx_en, 1);
    pop1(); pop1(); pop1();
    chk("t4_drained", empty, 1);

    // 5: prefix timeout
    send(8'hF0);
    idle(TO - 1);
    chk("t5_no_err_early", seq_error, 0);
    idle(1); err_exp++;
    chk("t5_timeout_err", seq_error, 1);
    idle(1);
    chk("t5_err_pulse", seq_error, 0);
    send(8'h1C); exp_q.push_back({2'b00, 8'h1C});
    pop1();

    // 6: reset mid-sequence and with queued events
    send(8'hE0);
    do_reset();
    send(8'h75); exp_q.push_back({2'b00, 8'h75});
    pop1();
    send(8'h15); send(8'h16); send(8'h1E);
    chk("t6_queued", empty, 0);
    do_reset();
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_rx_en", rx_en, 1);
    chk("t6_rst_no_err", seq_error, 0);

    idle(3);
    chk("err_count", err_seen, err_exp);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
